// File: rtl/pulp_clock_divider_cfg.sv
// Glitch-free runtime-configurable clock divider with optional output inversion.
// New ratio/inversion requests are applied only at a period boundary and acknowledged once.
module pulp_clock_divider_cfg #(
    parameter int unsigned DIV_WIDTH   = 8,
    parameter int unsigned DEFAULT_DIV = 1,
    parameter bit          DEFAULT_INV = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 test_mode_i,
    input  logic                 clk_div_valid_i,
    input  logic [DIV_WIDTH-1:0] clk_div_data_i,
    input  logic                 clk_inv_i,
    output logic                 clk_div_ack_o,
    output logic                 clk_o
);

    typedef enum logic {IDLE, PENDING} state_e;

    localparam logic [DIV_WIDTH-1:0] DEF_DIV = DIV_WIDTH'(DEFAULT_DIV);

    state_e               state;
    logic [DIV_WIDTH-1:0] div_q, pend_div, cnt, cnt_next;
    logic                 inv_q, pend_inv, started, div_clk;
    logic                 bypass, boundary;
    logic [DIV_WIDTH:0]   half;

    assign bypass   = (div_q < DIV_WIDTH'(2));
    // ceil(N/2) with one extra bit so N = 2^DIV_WIDTH-1 cannot overflow
    assign half     = ({1'b0, div_q} + (DIV_WIDTH+1)'(1)) >> 1;
    // the first edge after reset opens a fresh period
    assign boundary = bypass || !started || (cnt == div_q - 1'b1);
    assign cnt_next = boundary ? '0 : cnt + 1'b1;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state         <= IDLE;
            div_q         <= DEF_DIV;
            inv_q         <= DEFAULT_INV;
            pend_div      <= DEF_DIV;
            pend_inv      <= DEFAULT_INV;
            cnt           <= '0;
            started       <= 1'b0;
            div_clk       <= 1'b0;
            clk_div_ack_o <= 1'b0;
        end else begin
            started       <= 1'b1;
            clk_div_ack_o <= 1'b0;
            if (state == IDLE) begin
                if (clk_div_valid_i) begin
                    pend_div <= clk_div_data_i;
                    pend_inv <= clk_inv_i;
                    state    <= PENDING;
                end
                cnt     <= cnt_next;
                div_clk <= ({1'b0, cnt_next} < half);
            end else if (boundary) begin
                div_q         <= pend_div;
                inv_q         <= pend_inv;
                state         <= IDLE;
                clk_div_ack_o <= 1'b1;
                cnt           <= '0;
                div_clk       <= 1'b1;
            end else begin
                cnt     <= cnt_next;
                div_clk <= ({1'b0, cnt_next} < half);
            end
        end
    end

    // bypass and test paths are combinational so clk_o tracks clk_i directly
    always_comb begin
        if (test_mode_i) clk_o = clk_i;
        else             clk_o = (bypass ? clk_i : div_clk) ^ inv_q;
    end

endmodule

// File: tb/tb_pulp_clock_divider_cfg.sv
// Randomized bench for pulp_clock_divider_cfg: a period-position model predicts clk_o
// on both clk_i phases, and expected acks are queued for a decoupled monitor.
module tb_pulp_clock_divider_cfg;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          test_mode = 1'b0;
    logic          valid = 1'b0;
    logic [DW-1:0] data = '0;
    logic          inv = 1'b0;
    logic          ack;
    logic          clk_o;

    pulp_clock_divider_cfg #(.DIV_WIDTH(DW), .DEFAULT_DIV(1), .DEFAULT_INV(1'b0)) dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .test_mode_i    (test_mode),
        .clk_div_valid_i(valid),
        .clk_div_data_i (data),
        .clk_inv_i      (inv),
        .clk_div_ack_o  (ack),
        .clk_o          (clk_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    // model: active ratio, inversion, cycle position within the current period
    int mN, pN, pos;
    bit mI, pI, pend, fresh;
    int exp_ack[$];

    task automatic model_reset();
        mN = 1; mI = 1'b0; pN = 1; pI = 1'b0;
        pos = 0; pend = 1'b0; fresh = 1'b1;
        exp_ack.delete();
    endtask

    task automatic model_edge();
        bit was_pend = pend;
        bit bnd = (mN < 2) || fresh || (pos == mN - 1);
        if (was_pend && bnd) begin
            mN = pN; mI = pI; pend = 1'b0;
            exp_ack.push_back(cyc);
        end
        pos   = bnd ? 0 : pos + 1;
        fresh = 1'b0;
        if (!was_pend && valid) begin
            pN = int'(data); pI = inv; pend = 1'b1;
        end
    endtask

    task automatic check_clk(input bit ci);
        bit lvl;
        bit e;
        lvl = (mN < 2) ? ci : (!fresh && (pos < (mN + 1) / 2));
        e   = test_mode ? ci : (lvl ^ mI);
        checks++;
        if (clk_o === e) passes++;
        else $display("FAIL clk_o cyc=%0d phase=%0d N=%0d pos=%0d got=%b exp=%b",
                      cyc, ci, mN, pos, clk_o, e);
    endtask

    task automatic check_ack();
        bit due = (exp_ack.size() > 0) && (exp_ack[0] == cyc);
        checks++;
        if (ack === 1'b1) begin
            if (due) begin passes++; void'(exp_ack.pop_front()); end
            else $display("FAIL ack unexpected cyc=%0d got=1 exp=0", cyc);
        end else if (due) begin
            $display("FAIL ack missing cyc=%0d got=%b exp=1", cyc, ack);
            void'(exp_ack.pop_front());
        end else passes++;
    endtask

    // monitor
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            cyc++;
            if (!rstn) model_reset(); else model_edge();
            #1;
            check_ack();
            check_clk(1'b1);
            @(negedge clk);
            #1;
            if (!rstn) model_reset();
            check_clk(1'b0);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic req(input int d, input bit i, input int hold);
        @(negedge clk);
        valid = 1'b1; data = DW'(d); inv = i;
        repeat (hold) @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic pulse_reset(input int len);
        @(negedge clk);
        rstn = 1'b0;
        repeat (len) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        wait_cyc(3);
        rstn = 1'b1;
        wait_cyc(5);
        req(4, 0, 1);  wait_cyc(14);
        req(5, 0, 1);  wait_cyc(12);
        req(2, 0, 1);  wait_cyc(10);
        req(5, 0, 1);  wait_cyc(7);
        req(2, 0, 1);  wait_cyc(10);
        req(3, 0, 1);  wait_cyc(8);
        req(0, 1, 1);  wait_cyc(8);
        req(8, 0, 1);  wait_cyc(20);
        req(6, 0, 1);  req(7, 0, 1); wait_cyc(30);
        req(8, 1, 1);  wait_cyc(20);
        req(3, 0, 1);  wait_cyc(2);
        pulse_reset(2); wait_cyc(10);
        req(6, 1, 1);  wait_cyc(20);
        test_mode = 1'b1; wait_cyc(7);
        test_mode = 1'b0; wait_cyc(15);
        req(4, 0, 3);  wait_cyc(20);
        req(255, 0, 1); wait_cyc(600);
        req(1, 0, 1);  wait_cyc(5);
        for (int k = 0; k < 300; k++) begin
            int r = $urandom_range(0, 99);
            int d = (r < 4) ? $urandom_range(13, 60) : $urandom_range(0, 12);
            wait_cyc($urandom_range(0, 20));
            if (r >= 95)      pulse_reset($urandom_range(1, 3));
            else if (r >= 88) test_mode = ~test_mode;
            else              req(d, 1'($urandom_range(0, 1)), (r < 15) ? $urandom_range(2, 4) : 1);
        end
        test_mode = 1'b0;
        wait_cyc(600);
        checks++;
        if (exp_ack.size() == 0 && !pend) passes++;
        else $display("FAIL final queue got=%0d pend=%0d exp=0", exp_ack.size(), pend);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
